ras_checkpointed: RTL and testbench
===================================

// Module: ras_checkpointed
// PURPOSE
//  Return-address stack directly downstream of fetch: consumes ras_fetch_intf_o
//  (push/pop/new_addr/branch_fetched) and returns the predicted return target
//  via ras_fetch_intf_i.addr. Each fetched branch records a stack-pointer
//  checkpoint. Checkpoints are released at retire and restored on a
//  misprediction flush, so wrong-path calls and returns do not corrupt the stack.
// PARAMETERS
//  RAS_DEPTH    8  stack entries; power of 2, >=2
//  TRACK_DEPTH  8  in-flight branch checkpoints; power of 2, >=2
// PORTS
//  clk             in   1    clock; all state on rising edge
//  rst             in   1    asynchronous, active-low reset
//  fetch_ras       in   $bits(ras_fetch_intf_o)  push, pop, new_addr[31:0], branch_fetched
//  ras_fetch       out  $bits(ras_fetch_intf_i)  addr[31:0] = predicted return target
//  branch_retired  in   1    oldest tracked branch retired; release its checkpoint
//  flush           in   1    oldest tracked branch mispredicted; restore its checkpoint
//  track_overflow  out  1    sticky: branch_fetched seen while checkpoint FIFO full
// BEHAVIOUR
//  Reset (async assert, sync release): read_index=0, FIFO empty, track_overflow=0.
//   Stack contents are not reset; addr is undefined until the first push.
//  Stack: circular array, RAS_DEPTH x 32b, 1 write/1 async read.
//   addr = stack[read_index], combinational (0-cycle latency).
//   Mod-RAS_DEPTH arithmetic: overflow overwrites the oldest entry, underflow wraps.
//  Per cycle when flush=0 (ri = read_index):
//   push only   : stack[ri+1] <= new_addr; ri <= ri+1
//   pop only    : ri <= ri-1
//   push & pop  : stack[ri] <= new_addr; ri unchanged (replace top)
//   neither     : no change
//  Checkpoint FIFO (TRACK_DEPTH x log2(RAS_DEPTH)):
//   branch_fetched: enqueue next_ri, the read_index value after this cycle's
//    push/pop is applied.
//   branch_retired: dequeue the head.
//   fetched & retired in the same cycle: both happen; count unchanged, legal when full.
//   fetched while full and not retiring: entry dropped; track_overflow <= 1.
//    Assertion error.
//   retired while empty: ignored. Assertion error.
//  flush=1 (highest priority):
//   If FIFO non-empty: ri <= head checkpoint. If FIFO empty: ri unchanged.
//   FIFO cleared to empty.
//   Same-cycle push, pop, branch_fetched and branch_retired are discarded;
//    there is no stack write.
//  No internal FSM beyond the pointers and FIFO count. track_overflow clears
//   only on reset.
// STRUCTURE
//  No new package types; ports use the existing ras_fetch_intf_o/_i structs.
//  Index width is localparam $clog2(RAS_DEPTH), local to this module.
//  Sub-modules: lutram_1w_1r for the stack; cva5_fifo (DATA_WIDTH=index,
//   FIFO_DEPTH=TRACK_DEPTH) for the checkpoints, driven through the
//   fifo_structure_intf_i/_o structs.
// TESTING
//  1 push 0x100,0x200,0x300 -> addr 0x300; pop x2 -> addr 0x100.
//  2 RAS_DEPTH=8: push 0x10..0x90 (9 pushes) -> top 0x90; 8 pops -> addr 0x90
//    again (wrap; 0x10 overwritten).
//  3 push 0xA0, then push&pop 0xB0 in one cycle -> addr 0xB0, read_index
//    unchanged; pop -> addr shows prior top.
//  4 push 0x40 + branch_fetched; then wrong path push 0x50,0x60 + fetched x2;
//    flush -> addr 0x40, FIFO empty.
//  5 Fill FIFO (8 fetched), then fetched+retired together -> count 8,
//    overflow 0; a lone fetched -> track_overflow=1.
//  6 rst low mid-sequence (async, between edges) -> read_index=0, FIFO empty,
//    overflow 0 immediately; flush in the same cycle as push -> no stack write.

Source files
------------

// File: rtl/ras_checkpointed_pkg.sv
// ras_checkpointed_pkg: fetch/RAS and FIFO control interface structs
package ras_checkpointed_pkg;
  typedef struct packed {
    logic push;
    logic pop;
    logic [31:0] new_addr;
    logic branch_fetched;
  } ras_fetch_intf_o;

  typedef struct packed {
    logic [31:0] addr;
  } ras_fetch_intf_i;

  typedef struct packed {
    logic push;
    logic pop;
  } fifo_structure_intf_i;

  typedef struct packed {
    logic valid;
    logic full;
  } fifo_structure_intf_o;
endpackage

// File: rtl/cva5_fifo.sv
// cva5_fifo: circular FIFO with async head read, synchronous clear and full-with-pop acceptance
module cva5_fifo
  import ras_checkpointed_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  fifo_structure_intf_i  ctl,
  input  logic [DATA_WIDTH-1:0] data_in,
  output fifo_structure_intf_o  status,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic do_pop, do_push;

  assign status.valid = count != '0;
  assign status.full = count == (PW+1)'(FIFO_DEPTH);
  assign do_pop = ctl.pop & status.valid & ~clear;
  assign do_push = ctl.push & (~status.full | do_pop) & ~clear;
  assign data_out = mem[rd_ptr];

  // storage write; a push while full only lands when the head is leaving
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;

  // pointers and occupancy; clear empties the FIFO
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= wr_ptr + PW'(do_push);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/lutram_1w_1r.sv
// lutram_1w_1r: distributed RAM with one synchronous write port and one async read port
module lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] ram [DEPTH];

  // contents are deliberately not reset
  always_ff @(posedge clk)
    if (we) ram[waddr] <= wdata;

  assign rdata = ram[raddr];
endmodule

// File: rtl/ras_checkpointed.sv
// ras_checkpointed: return-address stack with per-branch pointer checkpoints for flush recovery
module ras_checkpointed
  import ras_checkpointed_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int TRACK_DEPTH = 8,
  parameter bit CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  ras_fetch_intf_o fetch_ras,
  output ras_fetch_intf_i ras_fetch,
  input  logic            branch_retired,
  input  logic            flush,
  output logic            track_overflow
);
  localparam int IW = $clog2(RAS_DEPTH);
  logic [IW-1:0] read_index, next_index, write_index, head;
  logic stack_we;
  fifo_structure_intf_i fifo_ctl;
  fifo_structure_intf_o fifo_status;

  // pointer after this cycle's push/pop; push&pop replaces the top in place
  always_comb begin
    next_index = (fetch_ras.push & ~fetch_ras.pop) ? read_index + IW'(1) :
                 (fetch_ras.pop & ~fetch_ras.push) ? read_index - IW'(1) : read_index;
    write_index = fetch_ras.pop ? read_index : read_index + IW'(1);
    stack_we = fetch_ras.push & ~flush;
    fifo_ctl.push = fetch_ras.branch_fetched & ~flush;
    fifo_ctl.pop = branch_retired & ~flush;
  end

  lutram_1w_1r #(.WIDTH(32), .DEPTH(RAS_DEPTH)) stack (
    .clk(clk),
    .we(stack_we),
    .waddr(write_index),
    .wdata(fetch_ras.new_addr),
    .raddr(read_index),
    .rdata(ras_fetch.addr)
  );

  cva5_fifo #(.DATA_WIDTH(IW), .FIFO_DEPTH(TRACK_DEPTH)) checkpoints (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .ctl(fifo_ctl),
    .data_in(next_index),
    .status(fifo_status),
    .data_out(head)
  );

  // flush rewinds to the oldest in-flight branch checkpoint, otherwise follow push/pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) read_index <= '0;
    else read_index <= flush ? (fifo_status.valid ? head : read_index) : next_index;

  // sticky flag for a checkpoint that had no room and was dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) track_overflow <= 1'b0;
    else if (~flush & fetch_ras.branch_fetched & fifo_status.full & ~branch_retired) track_overflow <= 1'b1;

  if (CHECK) begin : g_chk
    a_track_full: assert property (@(posedge clk) disable iff (!rst)
      !(!flush && fetch_ras.branch_fetched && fifo_status.full && !branch_retired));
    a_track_empty: assert property (@(posedge clk) disable iff (!rst)
      !(!flush && branch_retired && !fifo_status.valid));
  end
endmodule

// File: tb/tb_ras_checkpointed.sv
// tb_ras_checkpointed: directed and random stimulus against a queue-based RAS model
module tb_ras_checkpointed;
  import ras_checkpointed_pkg::*;
  localparam int D = 8;
  localparam int TD = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  ras_fetch_intf_o f;
  ras_fetch_intf_i r;
  logic br, fl, ovf;
  logic [31:0] m_stk [D];
  bit m_wr [D];
  int m_ri;
  int m_q[$];
  bit m_ovf;
  bit live;
  int total, bad;

  always #5 clk = ~clk;

  ras_checkpointed #(.RAS_DEPTH(D), .TRACK_DEPTH(TD), .CHECK(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_ras(f),
    .ras_fetch(r),
    .branch_retired(br),
    .flush(fl),
    .track_overflow(ovf)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_step();
    int sz, nri, w;
    sz = m_q.size();
    nri = m_ri;
    if (fl) begin
      if (sz > 0) m_ri = m_q[0];
      m_q.delete();
    end else begin
      if (f.push && !f.pop) nri = (m_ri + 1) % D;
      else if (f.pop && !f.push) nri = (m_ri + D - 1) % D;
      if (f.push) begin
        w = f.pop ? m_ri : (m_ri + 1) % D;
        m_stk[w] = f.new_addr;
        m_wr[w] = 1'b1;
      end
      if (br && sz > 0) void'(m_q.pop_front());
      if (f.branch_fetched) begin
        if (sz < TD || br) m_q.push_back(nri);
        else m_ovf = 1'b1;
      end
      m_ri = nri;
    end
  endtask

  task automatic cyc(input bit pu, input bit po, input logic [31:0] a, input bit bf, input bit b, input bit fx);
    f.push = pu;
    f.pop = po;
    f.new_addr = a;
    f.branch_fetched = bf;
    br = b;
    fl = fx;
    @(posedge clk);
    model_step();
    #1;
    f = '0;
    br = 1'b0;
    fl = 1'b0;
  endtask

  task automatic areset();
    #3 rst = 1'b0;
    m_ri = 0;
    m_q.delete();
    m_ovf = 1'b0;
    #1 chk("areset_ovf", ovf, 0);
    if (m_wr[0]) chk("areset_addr", r.addr, m_stk[0]);
    #2 rst = 1'b1;
  endtask

  always @(negedge clk)
    if (rst && live) begin
      if (m_wr[m_ri]) chk("addr", r.addr, m_stk[m_ri]);
      chk("overflow", ovf, m_ovf);
    end

  initial begin
    f = '0;
    br = 1'b0;
    fl = 1'b0;
    m_ri = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < D; i++) m_wr[i] = 1'b0;
    #12 rst = 1'b1;
    chk("reset_ovf", ovf, 0);
    live = 1'b1;
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0);
    chk("t1_push", r.addr, 32'h300);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t1_pop", r.addr, 32'h100);
    for (int i = 1; i <= 9; i++) cyc(1, 0, 32'(i * 16), 0, 0, 0);
    chk("t2_top", r.addr, 32'h90);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("t2_wrap", r.addr, 32'h90);
    cyc(1, 0, 32'hA0, 0, 0, 0);
    cyc(1, 1, 32'hB0, 0, 0, 0);
    chk("t3_replace", r.addr, 32'hB0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t3_pop", r.addr, 32'h90);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_flush_empty", r.addr, 32'h90);
    cyc(1, 0, 32'h40, 1, 0, 0);
    cyc(1, 0, 32'h50, 1, 0, 0);
    cyc(1, 0, 32'h60, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_restore", r.addr, 32'h40);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_fifo_cleared", r.addr, 32'h90);
    for (int i = 0; i < TD; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t5_full_both", ovf, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t5_overflow", ovf, 1);
    for (int i = 0; i < TD; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 32'h33, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_drained", r.addr, 32'h33);
    areset();
    chk("t6_addr_idx0", r.addr, 32'h70);
    cyc(1, 0, 32'h55, 0, 0, 0);
    cyc(1, 0, 32'h77, 0, 0, 0);
    cyc(1, 0, 32'h88, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 32'h99, 0, 0, 1);
    chk("t6_flush_push_idx", r.addr, 32'h55);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("t6_no_write", r.addr, 32'h77);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) areset();
    end
    live = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
